// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared ATM codes: rejection reasons, ledger states, controller options
package atm_pkg;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_NSF   = 3'd1;
    localparam logic [2:0] ERR_LIMIT = 3'd2;
    localparam logic [2:0] ERR_OVF   = 3'd3;
    localparam logic [2:0] ERR_BOTH  = 3'd4;

    localparam logic [1:0] OPT_BALANCE  = 2'b01;
    localparam logic [1:0] OPT_WITHDRAW = 2'b10;
    localparam logic [1:0] OPT_DEPOSIT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_APPLY  = 3'd3,
        ST_COMMIT = 3'd4
    } ledger_state_t;

endpackage

// File: rtl/account_ledger_if.sv
// rtl/account_ledger_if.sv - session controller to ledger request/response bundle
interface account_ledger_if #(
    parameter int N_ACCTS = 4,
    parameter int BAL_W   = 2,
    parameter int AMT_W   = 2
);
    localparam int ID_W = (N_ACCTS > 1) ? $clog2(N_ACCTS) : 1;

    logic             card_valid;
    logic [ID_W-1:0]  card_id;
    logic             wd_req;
    logic             dep_req;
    logic [AMT_W-1:0] amount;
    logic             session_end;
    logic [BAL_W-1:0] balance;
    logic             balance_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       err_code;

    modport master (
        output card_valid, card_id, wd_req, dep_req, amount, session_end,
        input  balance, balance_valid, busy, done, err, err_code
    );

    modport slave (
        input  card_valid, card_id, wd_req, dep_req, amount, session_end,
        output balance, balance_valid, busy, done, err, err_code
    );
endinterface

// File: rtl/account_ledger_acct_bank.sv
// rtl/account_ledger_acct_bank.sv - per-account balance register file
module acct_bank #(
    parameter int N_ACCTS  = 4,
    parameter int BAL_W    = 2,
    parameter int INIT_BAL = 2,
    parameter int ID_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [ID_W-1:0]  addr_i,
    input  logic [BAL_W-1:0] wdata_i,
    output logic [BAL_W-1:0] rdata_o
);
    logic [BAL_W-1:0] mem_q [N_ACCTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ACCTS; i++) begin
                mem_q[i] <= BAL_W'(INIT_BAL);
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/account_ledger.sv
// rtl/account_ledger.sv - account balances with per-session withdrawal limit
// Read / check / apply / commit FSM fed by the ATM session controller.
module account_ledger
    import atm_pkg::*;
#(
    parameter int N_ACCTS  = 4,
    parameter int BAL_W    = 2,
    parameter int AMT_W    = 2,
    parameter int INIT_BAL = 2,
    parameter int WD_LIMIT = 3
) (
    input  logic           clk,
    input  logic           rst,
    account_ledger_if.slave bus
);
    localparam int ID_W  = (N_ACCTS > 1) ? $clog2(N_ACCTS) : 1;
    localparam int SWD_W = $clog2(WD_LIMIT + 1) + 1;
    localparam int MX0   = (BAL_W > AMT_W) ? BAL_W : AMT_W;
    localparam int MX    = (MX0 > SWD_W) ? MX0 : SWD_W;
    localparam int CW    = MX + 1;

    localparam logic [CW-1:0] BAL_MAX_C = CW'((1 << BAL_W) - 1);
    localparam logic [CW-1:0] LIMIT_C   = CW'(WD_LIMIT);

    ledger_state_t    state_q, state_d;
    logic [ID_W-1:0]  card_q, card_d;
    logic [BAL_W-1:0] work_bal_q, work_bal_d;
    logic [SWD_W-1:0] session_wd_q, session_wd_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             wd_op_q, wd_op_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;

    logic [BAL_W-1:0] bank_rdata;
    logic             bal_valid;

    acct_bank #(
        .N_ACCTS (N_ACCTS),
        .BAL_W   (BAL_W),
        .INIT_BAL(INIT_BAL),
        .ID_W    (ID_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we_i   (state_q == ST_COMMIT),
        .addr_i (card_q),
        .wdata_i(work_bal_q),
        .rdata_o(bank_rdata)
    );

    // Request checks run on the live amount; the apply step uses the latched copy.
    logic [CW-1:0] bal_x, req_amt_x, amt_x, swd_x;
    assign bal_x     = CW'(work_bal_q);
    assign req_amt_x = CW'(bus.amount);
    assign amt_x     = CW'(amt_q);
    assign swd_x     = CW'(session_wd_q);

    always_comb begin
        state_d      = state_q;
        card_d       = card_q;
        work_bal_d   = work_bal_q;
        session_wd_d = session_wd_q;
        amt_d        = amt_q;
        wd_op_d      = wd_op_q;
        pend_d       = pend_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;

        unique case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (bus.card_valid) begin
                    card_d  = bus.card_id;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                work_bal_d   = bank_rdata;
                session_wd_d = '0;
                state_d      = ST_READY;
            end
            ST_READY: begin
                if (bus.session_end) begin
                    state_d = ST_IDLE;
                end else if (bus.wd_req && bus.dep_req) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BOTH;
                end else if (bus.wd_req) begin
                    if (req_amt_x > bal_x) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NSF;
                    end else if (swd_x + req_amt_x > LIMIT_C) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LIMIT;
                    end else begin
                        amt_d      = bus.amount;
                        wd_op_d    = 1'b1;
                        err_code_d = ERR_NONE;
                        state_d    = ST_APPLY;
                    end
                end else if (bus.dep_req) begin
                    if (bal_x + req_amt_x > BAL_MAX_C) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVF;
                    end else begin
                        amt_d      = bus.amount;
                        wd_op_d    = 1'b0;
                        err_code_d = ERR_NONE;
                        state_d    = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                if (bus.session_end) pend_d = 1'b1;
                if (wd_op_q) begin
                    work_bal_d   = BAL_W'(bal_x - amt_x);
                    session_wd_d = SWD_W'(swd_x + amt_x);
                end else begin
                    work_bal_d = BAL_W'(bal_x + amt_x);
                end
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = (pend_q || bus.session_end) ? ST_IDLE : ST_READY;
                pend_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            card_q       <= '0;
            work_bal_q   <= '0;
            session_wd_q <= '0;
            amt_q        <= '0;
            wd_op_q      <= 1'b0;
            pend_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            card_q       <= card_d;
            work_bal_q   <= work_bal_d;
            session_wd_q <= session_wd_d;
            amt_q        <= amt_d;
            wd_op_q      <= wd_op_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bal_valid         = (state_q == ST_READY) || (state_q == ST_APPLY) ||
                               (state_q == ST_COMMIT);
    assign bus.balance       = bal_valid ? work_bal_q : '0;
    assign bus.balance_valid = bal_valid;
    assign bus.busy          = (state_q == ST_APPLY) || (state_q == ST_COMMIT);
    assign bus.done          = (state_q == ST_COMMIT);
    assign bus.err           = err_q;
    assign bus.err_code      = err_code_q;
endmodule

// File: tb/tb_account_ledger.sv
// tb/tb_account_ledger.sv - directed scoreboard bench for account_ledger
module tb_account_ledger;
    logic clk;
    logic rst;

    account_ledger_if #(.N_ACCTS(4), .BAL_W(2), .AMT_W(2)) bus ();

    account_ledger #(
        .N_ACCTS(4), .BAL_W(2), .AMT_W(2), .INIT_BAL(2), .WD_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [2:0] code;
        logic [1:0] bal;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   m_acct [4];
    int   m_bal;
    int   m_swd;
    int   cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.done === 1'b1 || bus.err === 1'b1)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", {30'd0, bus.done, bus.err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_kind_err", {31'd0, bus.err}, {31'd0, e.is_err});
                chk("sb_kind_done", {31'd0, bus.done}, {31'd0, !e.is_err});
                if (e.is_err) chk("sb_err_code", {29'd0, bus.err_code}, {29'd0, e.code});
                else          chk("sb_balance", {30'd0, bus.balance}, {30'd0, e.bal});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_sess(input int id);
        bus.card_valid = 1'b1;
        bus.card_id    = 2'(id);
        tick();
        bus.card_valid = 1'b0;
        chk("load_not_valid", {31'd0, bus.balance_valid}, 32'd0);
        tick();
        cur   = id;
        m_bal = m_acct[id];
        m_swd = 0;
        chk("open_valid", {31'd0, bus.balance_valid}, 32'd1);
        chk("open_balance", {30'd0, bus.balance}, m_bal);
    endtask

    task automatic end_sess();
        bus.session_end = 1'b1;
        tick();
        bus.session_end = 1'b0;
        chk("end_valid", {31'd0, bus.balance_valid}, 32'd0);
        chk("end_balance", {30'd0, bus.balance}, 32'd0);
    endtask

    task automatic req(input logic wd, input logic dep, input int amt);
        exp_t e;
        logic acc;
        int   code;
        acc  = 1'b0;
        code = 0;
        if (wd && dep) code = 4;
        else if (wd) begin
            if (amt > m_bal) code = 1;
            else if (m_swd + amt > 3) code = 2;
            else acc = 1'b1;
        end else if (dep) begin
            if (m_bal + amt > 3) code = 3;
            else acc = 1'b1;
        end
        if (acc) begin
            if (wd) begin
                m_bal = m_bal - amt;
                m_swd = m_swd + amt;
            end else begin
                m_bal = m_bal + amt;
            end
            m_acct[cur] = m_bal;
        end
        e.is_err = !acc;
        e.code   = 3'(code);
        e.bal    = 2'(m_bal);
        sb_q.push_back(e);

        bus.wd_req  = wd;
        bus.dep_req = dep;
        bus.amount  = 2'(amt);
        tick();
        bus.wd_req  = 1'b0;
        bus.dep_req = 1'b0;
        bus.amount  = 2'd0;
        if (acc) begin
            chk("acc_busy_n1", {31'd0, bus.busy}, 32'd1);
            chk("acc_done_n1", {31'd0, bus.done}, 32'd0);
            chk("acc_errcode_clr", {29'd0, bus.err_code}, 32'd0);
            tick();
            chk("acc_done_n2", {31'd0, bus.done}, 32'd1);
            chk("acc_bal_n2", {30'd0, bus.balance}, m_bal);
            tick();
            chk("acc_busy_n3", {31'd0, bus.busy}, 32'd0);
            chk("acc_done_n3", {31'd0, bus.done}, 32'd0);
        end else begin
            chk("rej_err_n1", {31'd0, bus.err}, 32'd1);
            chk("rej_code", {29'd0, bus.err_code}, code);
            chk("rej_busy", {31'd0, bus.busy}, 32'd0);
            tick();
            chk("rej_err_pulse", {31'd0, bus.err}, 32'd0);
            chk("rej_code_held", {29'd0, bus.err_code}, code);
            chk("rej_bal_unch", {30'd0, bus.balance}, m_bal);
        end
    endtask

    initial begin
        exp_t e;
        rst             = 1'b1;
        bus.card_valid  = 1'b0;
        bus.card_id     = 2'd0;
        bus.wd_req      = 1'b0;
        bus.dep_req     = 1'b0;
        bus.amount      = 2'd0;
        bus.session_end = 1'b0;
        for (int i = 0; i < 4; i++) m_acct[i] = 2;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_balance", {30'd0, bus.balance}, 32'd0);
        chk("rst_valid", {31'd0, bus.balance_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_errcode", {29'd0, bus.err_code}, 32'd0);

        // Requests in IDLE must be ignored (monitor flags any output).
        bus.wd_req = 1'b1;
        bus.amount = 2'd1;
        tick();
        bus.wd_req = 1'b0;
        tick();
        chk("idle_ignore_busy", {31'd0, bus.busy}, 32'd0);

        open_sess(1);
        bus.card_valid = 1'b1;
        bus.card_id    = 2'd3;
        tick();
        bus.card_valid = 1'b0;
        chk("card_in_ready_ignored", {30'd0, bus.balance}, 32'd2);
        req(1'b1, 1'b0, 1);
        end_sess();
        open_sess(1);
        end_sess();
        open_sess(0);
        end_sess();

        open_sess(1);
        req(1'b1, 1'b0, 3);
        req(1'b0, 1'b1, 2);
        req(1'b1, 1'b0, 2);
        req(1'b1, 1'b0, 2);
        req(1'b0, 1'b1, 2);
        req(1'b1, 1'b0, 2);
        end_sess();

        open_sess(1);
        req(1'b1, 1'b0, 1);
        req(1'b0, 1'b1, 2);
        tick();
        chk("ovf_code_still_held", {29'd0, bus.err_code}, 32'd3);
        req(1'b0, 1'b1, 1);
        req(1'b1, 1'b1, 1);
        req(1'b1, 1'b0, 0);

        // session_end together with a request: the request is dropped.
        bus.session_end = 1'b1;
        bus.wd_req      = 1'b1;
        bus.amount      = 2'd1;
        tick();
        bus.session_end = 1'b0;
        bus.wd_req      = 1'b0;
        tick();
        chk("end_wins_busy", {31'd0, bus.busy}, 32'd0);
        chk("end_wins_valid", {31'd0, bus.balance_valid}, 32'd0);

        // session_end during APPLY: commit completes, then IDLE.
        open_sess(1);
        chk("pend_open_bal", {30'd0, bus.balance}, 32'd3);
        m_bal       = m_bal - 1;
        m_acct[cur] = m_bal;
        e.is_err = 1'b0;
        e.code   = 3'd0;
        e.bal    = 2'(m_bal);
        sb_q.push_back(e);
        bus.wd_req = 1'b1;
        bus.amount = 2'd1;
        tick();
        bus.wd_req      = 1'b0;
        bus.session_end = 1'b1;
        tick();
        bus.session_end = 1'b0;
        chk("pend_done", {31'd0, bus.done}, 32'd1);
        tick();
        chk("pend_idle_valid", {31'd0, bus.balance_valid}, 32'd0);
        chk("pend_idle_bal", {30'd0, bus.balance}, 32'd0);
        open_sess(1);
        chk("pend_committed", {30'd0, bus.balance}, 32'd2);

        // Reset during APPLY: no commit, every account back to INIT_BAL.
        bus.wd_req = 1'b1;
        bus.amount = 2'd2;
        tick();
        bus.wd_req = 1'b0;
        chk("rst_apply_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_acct[i] = 2;
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            open_sess(i);
            end_sess();
        end

        tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
